// File: rtl/aoi_pkg.sv
// Purpose: shared defaults and the AND-OR-INVERT evaluation function for aoi_pipe.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package aoi_pkg;

    localparam int AOI_GROUPS_DEF = 2;
    localparam int AOI_TERMS_DEF  = 2;
    localparam int AOI_STAGES_DEF = 2;
    localparam int AOI_INVERT_DEF = 1;
    localparam int AOI_CNT_W_DEF  = 8;

    // Upper bounds for the generic evaluator; callers zero-extend into these.
    localparam int AOI_MAX_G  = 16;
    localparam int AOI_MAX_T  = 16;
    localparam int AOI_MAX_IN = AOI_MAX_G * AOI_MAX_T;

    // Returns {res, grp} packed from bit 0 upward: bits [groups-1:0] are the
    // per-group ANDs, bit [groups] is the (optionally inverted) OR.
    // Group g occupies data[g*terms +: terms].
    function automatic logic [AOI_MAX_G:0] aoi_eval(
        input logic [AOI_MAX_IN-1:0] data,
        input int                    groups,
        input int                    terms,
        input logic                  invert
    );
        logic [AOI_MAX_G:0] r;
        logic               any_hit;
        logic               term_and;
        r       = '0;
        any_hit = 1'b0;
        for (int g = 0; g < AOI_MAX_G; g++) begin
            if (g < groups) begin
                term_and = 1'b1;
                for (int t = 0; t < AOI_MAX_T; t++) begin
                    if (t < terms) begin
                        term_and = term_and & data[g*terms + t];
                    end
                end
                r[g]    = term_and;
                any_hit = any_hit | term_and;
            end
        end
        r[groups] = any_hit ^ invert;
        return r;
    endfunction

endpackage

// File: rtl/aoi_stage.sv
// Purpose: one elastic valid/ready register slice with a parametrised payload.
// Latency: 1 cycle.
// Backpressure: in_ready_o = !valid | out_ready_i, combinational backward; full throughput.
// Ports: clk, rst_n; upstream in_valid_i/in_ready_o/in_data_i;
//        downstream out_valid_o/out_ready_i/out_data_o.
module aoi_stage #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         load;

    // Room exists when empty or when the current beat leaves this cycle.
    assign in_ready_o = !valid_q | out_ready_i;
    assign load       = in_valid_i & in_ready_o;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready_o) begin
            valid_d = in_valid_i;
        end
        if (load) begin
            data_d = in_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/aoi_pipe.sv
// Purpose: registered AND-OR-INVERT evaluator carried through STAGES elastic slices, with saturating hit counter.
// Latency: STAGES cycles from input acceptance to out_valid.
// Backpressure: ready ripples combinationally back from out_ready; holds up to STAGES beats, 1 beat/cycle.
// Ports: clk, rst_n; in_valid/in_ready/in_data (group g at [g*TERMS +: TERMS]);
//        out_valid/out_ready/out_data/out_groups; clr_count, hit_count.
module aoi_pipe
    import aoi_pkg::*;
#(
    parameter int GROUPS = AOI_GROUPS_DEF,
    parameter int TERMS  = AOI_TERMS_DEF,
    parameter int STAGES = AOI_STAGES_DEF,
    parameter int INVERT = AOI_INVERT_DEF,
    parameter int CNT_W  = AOI_CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [GROUPS*TERMS-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_data,
    output logic [GROUPS-1:0]       out_groups,
    input  logic                    clr_count,
    output logic [CNT_W-1:0]        hit_count
);

    // Payload layout: {res, grp[GROUPS-1:0]}.
    localparam int PW = GROUPS + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PW-1:0] payload;
    logic [PW-1:0] dat [0:STAGES];
    logic [STAGES:0] vld;
    logic [STAGES:0] rdy;

    // Evaluate at capture so every slice carries the finished result.
    assign payload = PW'(aoi_eval(AOI_MAX_IN'(in_data), GROUPS, TERMS, INVERT != 0));

    assign vld[0]      = in_valid;
    assign dat[0]      = payload;
    assign in_ready    = rdy[0];
    assign rdy[STAGES] = out_ready;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        aoi_stage #(.W(PW)) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid_i  (vld[s]),
            .in_ready_o  (rdy[s]),
            .in_data_i   (dat[s]),
            .out_valid_o (vld[s+1]),
            .out_ready_i (rdy[s+1]),
            .out_data_o  (dat[s+1])
        );
    end

    assign out_valid  = vld[STAGES];
    assign out_data   = dat[STAGES][GROUPS];
    assign out_groups = dat[STAGES][GROUPS-1:0];

    logic [CNT_W-1:0] hit_q, hit_d;

    // Clear wins over a same-cycle hit; the count sticks at all-ones.
    always_comb begin
        hit_d = hit_q;
        if (clr_count) begin
            hit_d = '0;
        end else if (out_valid && out_ready && out_data && (hit_q != CNT_MAX)) begin
            hit_d = hit_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q <= '0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit_count = hit_q;

endmodule

// File: tb/tb_aoi_pipe.sv
module tb_aoi_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [3:0] in_data;
    logic       out_valid, out_ready, out_data;
    logic [1:0] out_groups;
    logic       clr_count;
    logic [2:0] hit_count;

    logic       in_valid2, in_ready2;
    logic [8:0] in_data2;
    logic       out_valid2, out_ready2, out_data2;
    logic [2:0] out_groups2;
    logic       clr_count2;
    logic [7:0] hit_count2;

    int tests_run;
    int tests_failed;

    aoi_pipe #(.GROUPS(2), .TERMS(2), .STAGES(2), .INVERT(1), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_groups(out_groups), .clr_count(clr_count), .hit_count(hit_count)
    );

    aoi_pipe #(.GROUPS(3), .TERMS(3), .STAGES(1), .INVERT(0), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .out_groups(out_groups2), .clr_count(clr_count2), .hit_count(hit_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_count = 1'b0;
        in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0; clr_count2 = 1'b0;
        #12;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid got %0h want 0", out_valid); end
        tests_run++; if (out_data !== 1'b0) begin tests_failed++; $display("FAIL rst_out_data got %0h want 0", out_data); end
        tests_run++; if (out_groups !== 2'b00) begin tests_failed++; $display("FAIL rst_out_groups got %0h want 0", out_groups); end
        tests_run++; if (hit_count !== 3'd0) begin tests_failed++; $display("FAIL rst_hit_count got %0d want 0", hit_count); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_in_ready got %0h want 1", in_ready); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_idle_valid got %0h want 0", out_valid); end
    endtask

    task automatic test_single;
        logic [3:0] sv [3];
        logic       sd [3];
        logic [1:0] sg [3];
        sv = '{4'b0011, 4'b0101, 4'b1111};
        sd = '{1'b0, 1'b1, 1'b0};
        sg = '{2'b01, 2'b00, 2'b11};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); in_valid = 1'b1; in_data = sv[i]; out_ready = 1'b1;
            tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL single%0d_in_ready got %0h want 1", i, in_ready); end
            @(negedge clk); in_valid = 1'b0;
            tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL single%0d_early_valid got %0h want 0", i, out_valid); end
            @(negedge clk);
            tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL single%0d_valid got %0h want 1", i, out_valid); end
            tests_run++; if (out_data !== sd[i]) begin tests_failed++; $display("FAIL single%0d_data got %0h want %0h", i, out_data, sd[i]); end
            tests_run++; if (out_groups !== sg[i]) begin tests_failed++; $display("FAIL single%0d_groups got %0h want %0h", i, out_groups, sg[i]); end
            @(negedge clk);
            tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL single%0d_drained got %0h want 0", i, out_valid); end
        end
        tests_run++; if (hit_count !== 3'd1) begin tests_failed++; $display("FAIL single_hits got %0d want 1", hit_count); end
        @(negedge clk); clr_count = 1'b1;
        @(negedge clk); clr_count = 1'b0;
        tests_run++; if (hit_count !== 3'd0) begin tests_failed++; $display("FAIL single_clear got %0d want 0", hit_count); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] bv [8];
        logic       bd [8];
        logic [1:0] bg [8];
        bv = '{4'b0000, 4'b0011, 4'b1100, 4'b1111, 4'b1010, 4'b0110, 4'b0111, 4'b1001};
        bd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        bg = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00};
        out_ready = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            logic exp_v;
            @(negedge clk);
            exp_v = (c >= 2) && (c <= 9);
            tests_run++; if (out_valid !== exp_v) begin tests_failed++; $display("FAIL b2b_valid c%0d got %0h want %0h", c, out_valid, exp_v); end
            if (exp_v) begin
                tests_run++; if (out_data !== bd[c-2]) begin tests_failed++; $display("FAIL b2b_data beat%0d got %0h want %0h", c-2, out_data, bd[c-2]); end
                tests_run++; if (out_groups !== bg[c-2]) begin tests_failed++; $display("FAIL b2b_groups beat%0d got %0h want %0h", c-2, out_groups, bg[c-2]); end
            end
            if (c < 8) begin
                in_valid = 1'b1; in_data = bv[c];
                tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_in_ready c%0d got %0h want 1", c, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
        end
        tests_run++; if (hit_count !== 3'd4) begin tests_failed++; $display("FAIL b2b_hits got %0d want 4", hit_count); end
    endtask

    task automatic test_backpressure;
        @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; in_data = 4'b0011; #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_accept_a got %0h want 1", in_ready); end
        @(negedge clk); in_data = 4'b0000; #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_accept_b got %0h want 1", in_ready); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_early_valid got %0h want 0", out_valid); end
        @(negedge clk); in_data = 4'b1111; #1;
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_full got %0h want 0", in_ready); end
        tests_run++; if (out_valid !== 1'b1 || out_data !== 1'b0 || out_groups !== 2'b01) begin
            tests_failed++; $display("FAIL bp_head got v%0h d%0h g%0h want v1 d0 g1", out_valid, out_data, out_groups); end
        @(negedge clk); #1;
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_still_full got %0h want 0", in_ready); end
        tests_run++; if (out_valid !== 1'b1 || out_data !== 1'b0 || out_groups !== 2'b01) begin
            tests_failed++; $display("FAIL bp_stable got v%0h d%0h g%0h want v1 d0 g1", out_valid, out_data, out_groups); end
        tests_run++; if (hit_count !== 3'd4) begin tests_failed++; $display("FAIL bp_hits_held got %0d want 4", hit_count); end
        out_ready = 1'b1; #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready got %0h want 1", in_ready); end
        @(negedge clk); in_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b1 || out_data !== 1'b1 || out_groups !== 2'b00) begin
            tests_failed++; $display("FAIL bp_beat_b got v%0h d%0h g%0h want v1 d1 g0", out_valid, out_data, out_groups); end
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b1 || out_data !== 1'b0 || out_groups !== 2'b11) begin
            tests_failed++; $display("FAIL bp_beat_c got v%0h d%0h g%0h want v1 d0 g3", out_valid, out_data, out_groups); end
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drained got %0h want 0", out_valid); end
        tests_run++; if (hit_count !== 3'd5) begin tests_failed++; $display("FAIL bp_hits got %0d want 5", hit_count); end
    endtask

    task automatic test_saturation;
        @(negedge clk); clr_count = 1'b1;
        @(negedge clk); clr_count = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            int e;
            @(negedge clk);
            e = c - 2;
            if (e < 0) e = 0;
            if (e > 7) e = 7;
            tests_run++; if (hit_count !== 3'(e)) begin tests_failed++; $display("FAIL sat_count c%0d got %0d want %0d", c, hit_count, e); end
            if (c < 9) begin in_valid = 1'b1; in_data = 4'b0000; end
            else in_valid = 1'b0;
        end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL sat_drained got %0h want 0", out_valid); end
        @(negedge clk); in_valid = 1'b1; in_data = 4'b0000;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b1 || hit_count !== 3'd7) begin
            tests_failed++; $display("FAIL clr_setup got v%0h cnt%0d want v1 cnt7", out_valid, hit_count); end
        clr_count = 1'b1;
        @(negedge clk); clr_count = 1'b0;
        tests_run++; if (hit_count !== 3'd0) begin tests_failed++; $display("FAIL clr_priority got %0d want 0", hit_count); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL clr_transfer got %0h want 0", out_valid); end
    endtask

    task automatic test_reset_midflight;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); in_valid = 1'b1; in_data = 4'b0000;
        end
        @(negedge clk); in_valid = 1'b0;
        tests_run++; if (hit_count !== 3'd1 || out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL mid_setup got cnt%0d v%0h want cnt1 v1", hit_count, out_valid); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_valid got %0h want 0", out_valid); end
        tests_run++; if (hit_count !== 3'd0) begin tests_failed++; $display("FAIL mid_rst_count got %0d want 0", hit_count); end
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_stale c%0d got %0h want 0", c, out_valid); end
        end
        tests_run++; if (hit_count !== 3'd0) begin tests_failed++; $display("FAIL mid_post_count got %0d want 0", hit_count); end
    endtask

    task automatic test_cfg_wide;
        @(negedge clk); in_valid2 = 1'b1; in_data2 = 9'b111000000; out_ready2 = 1'b1;
        @(negedge clk);
        tests_run++; if (out_valid2 !== 1'b1 || out_data2 !== 1'b1 || out_groups2 !== 3'b100) begin
            tests_failed++; $display("FAIL wide_hit got v%0h d%0h g%0h want v1 d1 g4", out_valid2, out_data2, out_groups2); end
        in_data2 = 9'b011011011;
        @(negedge clk); in_valid2 = 1'b0;
        tests_run++; if (out_valid2 !== 1'b1 || out_data2 !== 1'b0 || out_groups2 !== 3'b000) begin
            tests_failed++; $display("FAIL wide_miss got v%0h d%0h g%0h want v1 d0 g0", out_valid2, out_data2, out_groups2); end
        tests_run++; if (hit_count2 !== 8'd1) begin tests_failed++; $display("FAIL wide_hits got %0d want 1", hit_count2); end
        @(negedge clk);
        tests_run++; if (out_valid2 !== 1'b0) begin tests_failed++; $display("FAIL wide_drained got %0h want 0", out_valid2); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_saturation();
        test_reset_midflight();
        test_cfg_wide();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
